retire_trace_unit: RTL
======================

Name: retire_trace_unit

Overview:
- Consumer at the far end of the MEM/WB pipeline buffer.
- Each cycle it samples the mem_wb_reg struct and decides whether a real instruction retired. For each retirement it rebuilds the architectural write-back (rd, write enable, write data).
- Packs each retirement into a trace record and buffers it in a small FIFO. Records drain over a valid/ready port to a debug/trace sink.
- Keeps a retired-instruction counter and a dropped-record counter for the testbench and debug logic.

Parameters:
- DEPTH, 8, trace FIFO entries; power of two, 2..64.
- CNT_W, 32, width of retire_cnt; wraps on overflow.
- DROP_W, 16, width of drop_cnt; saturates.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; state clears on a rising edge while reset==0.
- mem_wb  in  $bits(mem_wb_reg)  current MEM/WB buffer contents (Pipe_Buf_Reg_PKG::mem_wb_reg).
- wb_stall  in  1  MEM/WB buffer is holding; do not re-sample.
- clr  in  1  clears drop_cnt and overflow; does not touch the FIFO or retire_cnt.
- tr_valid  out  1  trace record available.
- tr_ready  in  1  sink accepts the record this cycle.
- tr_rec  out  $bits(retire_rec)  head trace record.
- retire_cnt  out  CNT_W  total retirements.
- drop_cnt  out  DROP_W  records lost to a full FIFO.
- overflow  out  1  sticky; set on the first drop.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values: tr_valid=0, tr_rec=0, retire_cnt=0, drop_cnt=0, overflow=0, fifo_level=0; FIFO pointers at 0. Reset mid-stream discards all queued records.
- Retire condition: retire = !wb_stall && (mem_wb.Curr_Instr != 32'h0). A zero word is a bubble/flush and is ignored. A stalled cycle never retires, so an instruction held N cycles retires exactly once.
- Write-back reconstruction (combinational, from mem_wb fields):
  - RWSel 2'b00: MemtoReg ? MemReadData : Alu_Result.
  - RWSel 2'b01: Pc_Four.
  - RWSel 2'b10: Imm_Out.
  - RWSel 2'b11: Pc_Imm.
  - we = RegWrite && (rd != 5'd0).
  - wdata is forced to 0 when !we.
- Record fields: pc = Pc_Four - 32'd4 (32-bit, wraps); instr = Curr_Instr; rd; we; wdata; seq = retire_cnt[15:0] before increment.
- Counting: on retire, retire_cnt += 1 (modulo 2^CNT_W). Dropped records also count, so seq gaps expose the loss.
- Push: on retire, push the record.
  - If the FIFO is full and no pop happens this cycle, drop the record, drop_cnt += 1 (saturating at all-ones), overflow <= 1.
- Pop: when tr_valid && tr_ready.
  - tr_rec is the registered head entry. It must stay stable while tr_valid && !tr_ready.
- Latency: a retirement on edge N gives tr_valid=1 with that record after edge N when the FIFO was empty (one-cycle retire-to-valid). There is no fall-through in the same cycle.
- Simultaneous push+pop:
  - When full: the pop frees a slot and the push is accepted; no drop, level unchanged.
  - When empty: only the push occurs (no pop possible); level becomes 1.
- Pointer wrap: pointers are log2(DEPTH)+1 bits. Full = MSBs differ and the rest are equal; empty = pointers equal.
- clr priority: if clr and a drop occur in the same cycle, clr wins (drop_cnt=0, overflow=0).
- X safety: tr_rec content is don't-care only while tr_valid=0. It is driven to 0 after reset.

Decomposition:
- Add to Pipe_Buf_Reg_PKG:
  - typedef retire_rec {logic [31:0] pc; logic [31:0] instr; logic [4:0] rd; logic we; logic [31:0] wdata; logic [15:0] seq;}
  - RWSel encoding constants RWSEL_ALU=2'b00, RWSEL_PC4=2'b01, RWSEL_IMM=2'b10, RWSEL_PCIMM=2'b11.
- One sub-module, trace_fifo: a parameterised synchronous FIFO (DEPTH, payload type). It has push/pop/full/empty/level and a registered head output.
- retire_trace_unit holds the retire detection, write-back mux, counters and drop logic.

Test Plan:
- Reset, then a single ALU instr (instr=32'h00500093, RWSel=00, MemtoReg=0, Alu_Result=5, rd=1, RegWrite=1, Pc_Four=32'h8) with tr_ready=1 -> next cycle tr_valid=1, pc=4, we=1, wdata=5, seq=0; retire_cnt=1.
- Bubble (Curr_Instr=0) for 3 cycles, then the same instr with wb_stall=1 for 2 cycles, then 0 -> retire_cnt unchanged after the bubbles; exactly one record after the stall releases.
- Write-back mux: RWSel=01 with Pc_Four=32'h20 -> wdata=32'h20; RWSel=00 with MemtoReg=1, MemReadData=32'hDEADBEEF -> wdata=32'hDEADBEEF; rd=0 with RegWrite=1 -> we=0, wdata=0.
- tr_ready=0, 10 back-to-back retirements, DEPTH=8 -> fifo_level=8, drop_cnt=2, overflow=1. Draining gives seq 0..7; retire_cnt=10.
- Full FIFO with tr_ready=1 and a retire in the same cycle -> no drop, level stays 8. Then pulse clr -> drop_cnt=0, overflow=0.
- Assert reset (reset=0) for one cycle with 5 queued records -> tr_valid=0, fifo_level=0, retire_cnt=0 next cycle.

Source files
------------

// File: rtl/retire_trace_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : Pipe_Buf_Reg_PKG
// Description : MEM/WB pipeline buffer layout, retirement trace record and
//               write-back source select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package Pipe_Buf_Reg_PKG;

    // MEM/WB buffer contents as seen by the write-back stage
    typedef struct packed {
        logic [31:0] Curr_Instr;
        logic [31:0] Pc_Four;
        logic [31:0] Pc_Imm;
        logic [31:0] Imm_Out;
        logic [31:0] Alu_Result;
        logic [31:0] MemReadData;
        logic [4:0]  rd;
        logic [1:0]  RWSel;
        logic        MemtoReg;
        logic        RegWrite;
    } mem_wb_reg;

    // One retired instruction as handed to the trace sink
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
        logic [15:0] seq;
    } retire_rec;

    // Write-back source select
    localparam logic [1:0] RWSEL_ALU   = 2'b00;
    localparam logic [1:0] RWSEL_PC4   = 2'b01;
    localparam logic [1:0] RWSEL_IMM   = 2'b10;
    localparam logic [1:0] RWSEL_PCIMM = 2'b11;

endpackage
`default_nettype wire

// File: rtl/retire_trace_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_unit_if
// Description : valid/ready trace record port between the retire trace unit
//               (master) and a debug/trace sink (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface retire_trace_unit_if;
    import Pipe_Buf_Reg_PKG::*;

    logic      tr_valid;
    logic      tr_ready;
    retire_rec tr_rec;

    modport master (output tr_valid, output tr_rec, input  tr_ready);
    modport slave  (input  tr_valid, input  tr_rec, output tr_ready);

endinterface
`default_nettype wire

// File: rtl/retire_trace_unit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous FIFO with extended (wrap-bit) pointers and a
//               registered head entry that is stable until popped.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = retire_rec
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push_i,
    input  wire T                       din_i,
    input  wire logic                   pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      level_o,
    output T                            head_o
);

    localparam int              C_AW      = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_PTR_ONE = 1;

    logic [C_AW:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW:0] rd_ptr_q, rd_ptr_d;
    T              head_q,   head_d;
    T              mem_q [DEPTH];

    logic w_full, w_empty, w_do_push, w_do_pop;

    assign w_full    = (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]) &&
                       (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]);
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_do_pop  = pop_i && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_do_push = push_i && (!w_full || w_do_pop);

    // Pointer advance and next head selection (bypass when the new head is
    // the entry being written this cycle)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            if (rd_ptr_d == wr_ptr_q) begin
                head_d = din_i;
            end else begin
                head_d = mem_q[rd_ptr_d[C_AW-1:0]];
            end
        end else if (w_empty && w_do_push) begin
            head_d = din_i;
        end
    end

    // Pointer and head registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents behind the pointers need no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[C_AW-1:0]] <= din_i;
        end
    end

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = head_q;

endmodule
`default_nettype wire

// File: rtl/retire_trace_unit.sv
`default_nettype none
// ============================================================================
// Module      : retire_trace_unit
// Description : Detects instruction retirement from the MEM/WB buffer,
//               rebuilds the architectural write-back, and queues a trace
//               record per retirement with retire/drop accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    parameter int DROP_W = 16
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire mem_wb_reg               mem_wb,
    input  wire logic                    wb_stall,
    input  wire logic                    clr,
    retire_trace_unit_if.master          tr,
    output logic [CNT_W-1:0]             retire_cnt,
    output logic [DROP_W-1:0]            drop_cnt,
    output logic                         overflow,
    output logic [$clog2(DEPTH):0]       fifo_level
);

    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q,   drop_cnt_d;
    logic              overflow_q,   overflow_d;

    logic        w_retire, w_we, w_full, w_empty, w_pop, w_drop;
    logic [31:0] w_wb_val, w_wdata;
    retire_rec   w_rec, w_head;

    // A zero instruction word is a bubble; a held buffer is never re-sampled
    assign w_retire = !wb_stall && (mem_wb.Curr_Instr != 32'h0);
    assign w_pop    = !w_empty && tr.tr_ready;
    assign w_drop   = w_retire && w_full && !w_pop;

    // Write-back reconstruction and trace record assembly
    always_comb begin
        w_wb_val = '0;
        case (mem_wb.RWSel)
            RWSEL_ALU: w_wb_val = mem_wb.MemtoReg ? mem_wb.MemReadData : mem_wb.Alu_Result;
            RWSEL_PC4: w_wb_val = mem_wb.Pc_Four;
            RWSEL_IMM: w_wb_val = mem_wb.Imm_Out;
            default:   w_wb_val = mem_wb.Pc_Imm;
        endcase
        w_we      = mem_wb.RegWrite && (mem_wb.rd != 5'd0);
        w_wdata   = w_we ? w_wb_val : 32'h0;
        w_rec       = '0;
        w_rec.pc    = mem_wb.Pc_Four - 32'd4;
        w_rec.instr = mem_wb.Curr_Instr;
        w_rec.rd    = mem_wb.rd;
        w_rec.we    = w_we;
        w_rec.wdata = w_wdata;
        w_rec.seq   = retire_cnt_q[15:0];
    end

    // Retire counter wraps; drop counter saturates; clear beats a drop
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        if (w_retire) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        if (clr) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (w_drop) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
            overflow_d = 1'b1;
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (retire_rec)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_retire),
        .din_i   (w_rec),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level),
        .head_o  (w_head)
    );

    assign tr.tr_valid = !w_empty;
    assign tr.tr_rec   = w_head;
    assign retire_cnt  = retire_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire
